ff256_ct_seq_result_demultiplexer: RTL and testbench
====================================================

# ff256_ct_seq_result_demultiplexer

Scatter-accumulator at the output side of the sequential GF(256) cosine transform. Each accepted beat carries 8 lane products x_beta_out[i] (from the 8 constant multipliers) plus a 3-bit destination selector per lane. Each product is XOR-accumulated (GF(256) addition) into byte selector[i] of a 64-bit result register. On the last beat of a transform, the completed 64-bit word is handed off through a valid/ready output stage. This is the inverse of the input-side 64→8 byte gather: it scatters 8 bytes back into a 64-bit word.

## Interface
- MAX_BEATS, default 8: beats allowed per transform before overflow is flagged.
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_last  input  1  final beat of the current transform.
- lane_en  input  8  lane i contributes only if lane_en[i]=1.
- selector  input  3 × [0:7]  destination byte index per lane.
- x_beta_out  input  8 × [0:7]  lane products.
- y_out  output  64  completed transform word; byte k = y_out[8k+7:8k].
- y_valid  output  1  y_out holds a completed word.
- y_ready  input  1  consumer accepts y_out when y_valid && y_ready.
- err_overflow  output  1  sticky; set when a transform exceeds MAX_BEATS beats.

## Operation
- Beat scatter: for each byte k, contrib[k] = XOR over all i with lane_en[i] && selector[i]==k of x_beta_out[i]. More than one lane may target the same k; all of them are XORed. A byte with no contributing lane gets contrib 0.
- acc_next = acc ^ contrib (64-bit XOR).
- Accepted beat with in_last=0: acc <= acc_next, beat_cnt <= beat_cnt+1.
- Accepted beat with in_last=1: y_out <= acc_next, y_valid <= 1, acc <= 0, beat_cnt <= 0. The next transform starts clean.
- Output handoff: y_valid && y_ready with no new last beat clears y_valid. y_out holds its value.
- in_ready = !y_valid || y_ready (one output register, pass-through backpressure). While y_valid=1 and y_ready=0, no beats are accepted, and y_out and acc hold.
- Simultaneous events: y_ready handshake and an accepted last beat in the same cycle load the new word, and y_valid stays 1.
- Overflow: an accepted beat with in_last=0 when beat_cnt==MAX_BEATS-1 sets err_overflow. That beat is still accumulated and beat_cnt saturates at MAX_BEATS-1. err_overflow clears only on reset.
- in_valid=0 has no effect on acc, regardless of the other inputs.

## Timing
- Reset values (rst_n=0 at a clk edge): acc=0, y_out=0, y_valid=0, beat_cnt=0, err_overflow=0. in_ready is 1 in the first cycle after reset.
- Reset mid-transform: the partial accumulation and any pending y_out are discarded, with no output.
- Latency: y_valid rises on the edge that accepts the last beat, so y_out is visible the cycle after in_last is accepted.
- Throughput: one beat per cycle. Back-to-back single-beat transforms sustain 1 word/cycle while y_ready=1.
- in_ready is combinational from y_valid and y_ready. No other combinational input-to-output paths exist.
- y_out must remain stable while y_valid=1 and y_ready=0.

## Structure
- Shared package (ff256_ct_seq_defines): N_LANES=8, SEL_W=3, BYTE_W=8, WORD_W=64, and the byte-array typedef for selector/lane arrays.
- One sub-module: ff256_ct_seq_demux_8_64 (combinational scatter of 8 lanes into a 64-bit contrib word). It is instantiated once and mirrors the input-side 64→8 mux.
- Top level holds acc, beat_cnt, the output register and the handshake logic.

## Test plan
- Single beat, identity routing: selector[i]=i, lane_en=8'hFF, x_beta_out[i]=8'h10+i, in_last=1 → next cycle y_valid=1, y_out=64'h17161514_13121110.
- Collision XOR: all lanes selector=3, x_beta_out={01,02,04,08,10,20,40,80}, lane_en=FF, last → y_out byte3=8'hFF, other bytes 0.
- Multi-beat accumulation: beat A byte0=8'hA5, beat B byte0=8'h5A, beat C byte0=8'hFF (last) → y_out=64'h0 (A5^5A^FF=00). A following single beat byte0=8'h01 yields y_out=64'h01, proving acc was cleared.
- Backpressure: hold y_ready=0 after a completed word, drive 3 more beats → in_ready=0, y_out unchanged. Raise y_ready → beats accepted next cycle. A concurrent last beat plus y_ready keeps y_valid=1 with the new word.
- Overflow: MAX_BEATS=8, 9 beats without last → err_overflow=1 on the 8th accepted beat, and it stays set until rst_n=0.
- Reset mid-transform: 2 beats accumulated, rst_n=0 for one cycle, then one last beat byte1=8'h33 → y_out=64'h3300.

Source files
------------

// File: rtl/ff256_ct_seq_defines.sv
`default_nettype none
// ============================================================================
// Module      : ff256_ct_seq_defines (package)
// Description : Shared widths and lane-array types for the output side of the
//               sequential GF(256) cosine transform.
//               N_LANES lanes of BYTE_W-bit products, each routed to one of
//               N_LANES bytes of a WORD_W-bit result word.
// Revision    : 1.0 - initial release
// ============================================================================
package ff256_ct_seq_defines;

   localparam int N_LANES = 8;
   localparam int SEL_W   = 3;
   localparam int BYTE_W  = 8;
   localparam int WORD_W  = 64;

   // Per-lane destination byte index, lane i at element [i].
   typedef logic [N_LANES-1:0][SEL_W-1:0]  sel_arr_t;
   // Per-lane product byte, lane i at element [i].
   typedef logic [N_LANES-1:0][BYTE_W-1:0] byte_arr_t;

endpackage : ff256_ct_seq_defines
`default_nettype wire

// File: rtl/ff256_ct_seq_demux_8_64.sv
`default_nettype none
// ============================================================================
// Module      : ff256_ct_seq_demux_8_64
// Description : Combinational scatter of 8 lane products into a 64-bit word.
//               Byte k of contrib is the GF(256) sum (XOR) of every enabled
//               lane whose selector equals k; bytes nobody targets are zero.
//               Counterpart of the input-side 64->8 byte gather.
// Ports       : lane_en    [8]      lane enables
//               selector   [8][3]   destination byte per lane
//               x_beta_out [8][8]   lane products
//               contrib    [64]     scattered contribution word
// Revision    : 1.0 - initial release
// ============================================================================
module ff256_ct_seq_demux_8_64
   import ff256_ct_seq_defines::*;
(
   input  logic [N_LANES-1:0] lane_en,
   input  sel_arr_t           selector,
   input  byte_arr_t          x_beta_out,
   output logic [WORD_W-1:0]  contrib
);

   // One reduction tree per destination byte; collisions simply XOR together.
   for (genvar k = 0; k < N_LANES; k++) begin : g_byte
      logic [BYTE_W-1:0] byte_sum;

      always_comb begin
         byte_sum = '0;
         for (int i = 0; i < N_LANES; i++) begin
            if (lane_en[i] && (selector[i] == SEL_W'(k))) begin
               byte_sum = byte_sum ^ x_beta_out[i];
            end
         end
      end

      assign contrib[k*BYTE_W +: BYTE_W] = byte_sum;
   end

endmodule : ff256_ct_seq_demux_8_64
`default_nettype wire

// File: rtl/ff256_ct_seq_result_demultiplexer.sv
`default_nettype none
// ============================================================================
// Module      : ff256_ct_seq_result_demultiplexer
// Description : Scatter-accumulator at the transform output. Every accepted
//               beat XORs its scattered lane products into a 64-bit
//               accumulator; the beat marked in_last hands the finished word
//               to a single valid/ready output register and restarts clean.
//               A transform longer than MAX_BEATS beats raises a sticky flag.
// Ports       : clk, rst_n          clock, synchronous active-low reset
//               in_valid/in_ready   beat handshake
//               in_last             final beat of the transform
//               lane_en [8]         lane enables
//               selector [8][3]     destination byte per lane
//               x_beta_out [8][8]   lane products
//               y_out [64]          completed word, byte k = y_out[8k+7:8k]
//               y_valid/y_ready     output handshake
//               err_overflow        sticky beat-count overflow
// Revision    : 1.0 - initial release
// ============================================================================
module ff256_ct_seq_result_demultiplexer
   import ff256_ct_seq_defines::*;
#(
   parameter int MAX_BEATS = 8
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_last,
   input  logic [N_LANES-1:0] lane_en,
   input  sel_arr_t           selector,
   input  byte_arr_t          x_beta_out,
   output logic [WORD_W-1:0]  y_out,
   output logic               y_valid,
   input  logic               y_ready,
   output logic               err_overflow
);

   localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] contrib;
   logic [WORD_W-1:0] acc_next;
   logic [CNT_W-1:0]  beat_cnt;
   logic              accept;

   ff256_ct_seq_demux_8_64 u_demux (
      .lane_en    (lane_en),
      .selector   (selector),
      .x_beta_out (x_beta_out),
      .contrib    (contrib)
   );

   // Single output register: a beat may enter only if the slot is free or
   // is being emptied this very cycle.
   assign in_ready = !y_valid || y_ready;
   assign accept   = in_valid && in_ready;
   assign acc_next = acc ^ contrib;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc          <= '0;
         y_out        <= '0;
         y_valid      <= 1'b0;
         beat_cnt     <= '0;
         err_overflow <= 1'b0;
      end else begin
         // Draining first; an accepted last beat below re-asserts y_valid,
         // which covers the simultaneous drain-and-refill case.
         if (y_valid && y_ready) begin
            y_valid <= 1'b0;
         end

         if (accept) begin
            if (in_last) begin
               y_out    <= acc_next;
               y_valid  <= 1'b1;
               acc      <= '0;
               beat_cnt <= '0;
            end else begin
               acc <= acc_next;
               // Counter saturates; the overrunning beat is still summed.
               if (beat_cnt == CNT_LAST) begin
                  err_overflow <= 1'b1;
               end else begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule : ff256_ct_seq_result_demultiplexer
`default_nettype wire

// File: tb/tb_ff256_ct_seq_result_demultiplexer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ff256_ct_seq_result_demultiplexer
// Description : Directed self-checking bench for the result demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ff256_ct_seq_result_demultiplexer;
   import ff256_ct_seq_defines::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic              in_last;
   logic [N_LANES-1:0] lane_en;
   sel_arr_t          selector;
   byte_arr_t         x_beta_out;
   logic [WORD_W-1:0] y_out;
   logic              y_valid;
   logic              y_ready;
   logic              err_overflow;

   int checks   = 0;
   int failures = 0;

   ff256_ct_seq_result_demultiplexer #(.MAX_BEATS(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_last      (in_last),
      .lane_en      (lane_en),
      .selector     (selector),
      .x_beta_out   (x_beta_out),
      .y_out        (y_out),
      .y_valid      (y_valid),
      .y_ready      (y_ready),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_lanes();
      lane_en    = '0;
      selector   = '0;
      x_beta_out = '0;
   endtask

   // Single active lane 0 routed to byte b with value v.
   task automatic one_lane(input int b, input logic [7:0] v);
      clear_lanes();
      lane_en[0]    = 1'b1;
      selector[0]   = 3'(b);
      x_beta_out[0] = v;
   endtask

   task automatic beat(input logic last);
      in_valid = 1'b1;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      y_ready  = 1'b1;
      clear_lanes();
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state
      check("rst_y_valid", 64'(y_valid), 64'd0);
      check("rst_y_out", y_out, 64'd0);
      check("rst_err", 64'(err_overflow), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Identity routing, single beat
      lane_en = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         selector[i]   = 3'(i);
         x_beta_out[i] = 8'(8'h10 + i);
      end
      beat(1'b1);
      check("ident_valid", 64'(y_valid), 64'd1);
      check("ident_y_out", y_out, 64'h17161514_13121110);

      // All lanes collide on byte 3, back-to-back with the previous word
      for (int i = 0; i < 8; i++) begin
         selector[i]   = 3'd3;
         x_beta_out[i] = 8'(1 << i);
      end
      beat(1'b1);
      check("coll_valid", 64'(y_valid), 64'd1);
      check("coll_y_out", y_out, 64'h00000000_FF000000);

      // Multi-beat accumulation; disabled lane 1 carries garbage to byte 0
      one_lane(0, 8'hA5);
      selector[1]   = 3'd0;
      x_beta_out[1] = 8'h77;
      beat(1'b0);
      check("mb_valid_drained", 64'(y_valid), 64'd0);
      // Idle cycle with garbage on enabled lanes must not touch acc
      lane_en = 8'hFF;
      tick();
      one_lane(0, 8'h5A);
      beat(1'b0);
      one_lane(0, 8'hFF);
      beat(1'b1);
      check("mb_y_out", y_out, 64'h0);
      check("mb_valid", 64'(y_valid), 64'd1);
      one_lane(0, 8'h01);
      beat(1'b1);
      check("mb_cleared", y_out, 64'h01);

      // Backpressure
      one_lane(2, 8'h44);
      beat(1'b1);
      check("bp_word", y_out, 64'h00000000_00440000);
      y_ready = 1'b0;
      #1;
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      one_lane(0, 8'h11);
      in_valid = 1'b1;
      in_last  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("bp_hold_y_out", y_out, 64'h00000000_00440000);
         check("bp_hold_valid", 64'(y_valid), 64'd1);
         check("bp_hold_ready", 64'(in_ready), 64'd0);
      end
      // Drain and refill in the same cycle; stalled beats were never summed
      one_lane(0, 8'h22);
      in_last = 1'b1;
      y_ready = 1'b1;
      #1;
      check("bp_in_ready_high", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("bp_refill_valid", 64'(y_valid), 64'd1);
      check("bp_refill_y_out", y_out, 64'h22);
      tick();
      check("bp_drain_valid", 64'(y_valid), 64'd0);
      check("bp_drain_hold", y_out, 64'h22);

      // Overflow at MAX_BEATS=8: flag rises on the 8th non-last beat
      for (int b = 0; b < 7; b++) begin
         one_lane(b, 8'h01);
         beat(1'b0);
      end
      check("ovf_not_yet", 64'(err_overflow), 64'd0);
      one_lane(7, 8'h01);
      beat(1'b0);
      check("ovf_set", 64'(err_overflow), 64'd1);
      one_lane(0, 8'h80);
      beat(1'b0);
      check("ovf_sticky", 64'(err_overflow), 64'd1);
      one_lane(1, 8'h00);
      beat(1'b1);
      // Bytes 1..7 got 01; byte 0 got 01^80
      check("ovf_word", y_out, 64'h01010101_01010181);
      check("ovf_sticky_last", 64'(err_overflow), 64'd1);
      tick();
      check("ovf_sticky_idle", 64'(err_overflow), 64'd1);

      // Reset mid-transform
      one_lane(1, 8'h55);
      beat(1'b0);
      one_lane(1, 8'h0F);
      beat(1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst_valid", 64'(y_valid), 64'd0);
      check("mrst_y_out", y_out, 64'd0);
      check("mrst_err", 64'(err_overflow), 64'd0);
      one_lane(1, 8'h33);
      beat(1'b1);
      check("mrst_y_out_new", y_out, 64'h3300);
      check("mrst_valid_new", 64'(y_valid), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_ff256_ct_seq_result_demultiplexer
`default_nettype wire
